// File: rtl/game_pkg.sv
// game_pkg: shared board geometry, cell/board types, spawner FSM states and
// LFSR tap mask for the 2048-style board datapath.
package game_pkg;
    localparam int BOARD_N = 8;
    localparam int CELL_W  = 9;
    localparam int CELLS   = BOARD_N * BOARD_N;
    localparam int RC_W    = $clog2(BOARD_N);
    localparam int IDX_W   = 2 * RC_W;

    typedef logic [CELL_W-1:0] cell_t;
    typedef cell_t [BOARD_N-1:0][BOARD_N-1:0] board_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_COUNT  = 3'd1,
        S_PICK   = 3'd2,
        S_PLACE  = 3'd3,
        S_FINISH = 3'd4
    } spawn_state_t;

    // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0].
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/tile_spawner_if.sv
// tile_spawner_if: start/board handshake between the movement stage and the
// tile spawner, plus the registered board and status flags coming back.
interface tile_spawner_if;
    import game_pkg::*;

    logic   start;
    logic   moved;
    board_t board_in;
    board_t board_out;
    logic   busy;
    logic   done;
    logic   spawned;
    logic   game_won;
    logic   game_over;

    modport master (
        output start, moved, board_in,
        input  board_out, busy, done, spawned, game_won, game_over
    );

    modport slave (
        input  start, moved, board_in,
        output board_out, busy, done, spawned, game_won, game_over
    );
endinterface

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, loaded with seed on reset.
module lfsr16
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] out
);
    // Shift left every cycle, feeding back the XOR of the tapped bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) out <= seed;
        else      out <= {out[14:0], ^(out & LFSR_TAPS)};
    end
endmodule

// File: rtl/tile_spawner.sv
// tile_spawner: after each completed move, scans the board for empties, picks
// one pseudo-randomly, places a new tile there and registers the result along
// with sticky win / game-over flags.
// Build macro SPAWN_FOUR_EN: when defined, the new tile is 4 with probability
// 1/8 (lfsr[9:7]==0 at PICK); otherwise it is always 2.
module tile_spawner
    import game_pkg::*;
#(
    parameter int          WIN_VALUE = 256,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst,
    tile_spawner_if.slave bus
);
    localparam cell_t            WIN_CELL = cell_t'(WIN_VALUE);
    localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};
    localparam logic [RC_W-1:0]  RC_MAX   = {RC_W{1'b1}};
    localparam logic [RC_W-1:0]  RC_ONE   = RC_W'(1);
    localparam int               PROD_W   = 2 * IDX_W + 1;

    spawn_state_t       state;
    board_t             work, work_w, board_q;
    logic [15:0]        lfsr;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W:0]     empty_cnt, seen, target;
    logic [PROD_W-1:0]  prod;
    logic [RC_W-1:0]    row, col;
    cell_t              cur, spawn_val, spawn_nx;
    logic               moved_q, any_pair, win_hit, spawned_q, won_q, over_q;
    logic               is_empty, pair_hit, place_hit, no_spawn, go_finish;
    logic               unused_lfsr;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .out  (lfsr)
    );

    assign row         = idx[IDX_W-1:RC_W];
    assign col         = idx[RC_W-1:0];
    assign unused_lfsr = ^lfsr[15:IDX_W];

`ifdef SPAWN_FOUR_EN
    assign spawn_nx = (lfsr[9:7] == 3'b000) ? cell_t'(4) : cell_t'(2);
`else
    assign spawn_nx = cell_t'(2);
`endif

    // Per-cell view shared by both scans, plus the board with this cycle's spawn applied.
    always_comb begin
        cur      = work[row][col];
        is_empty = (cur == '0);
        pair_hit = 1'b0;
        if (!is_empty && (col != RC_MAX) && (cur == work[row][col + RC_ONE])) pair_hit = 1'b1;
        if (!is_empty && (row != RC_MAX) && (cur == work[row + RC_ONE][col])) pair_hit = 1'b1;
        place_hit = (state == S_PLACE) && is_empty && (seen == target);
        work_w    = work;
        if (place_hit) work_w[row][col] = spawn_val;
        no_spawn  = !moved_q || (empty_cnt == '0);
        go_finish = ((state == S_PICK) && no_spawn) ||
                    ((state == S_PLACE) && (idx == LAST_IDX));
        // Scales a 6-bit random fraction onto 0..empty_cnt-1.
        prod = PROD_W'(lfsr[IDX_W-1:0]) * PROD_W'(empty_cnt);
    end

    // Control FSM, scan counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            empty_cnt <= '0;
            seen      <= '0;
            moved_q   <= 1'b0;
            any_pair  <= 1'b0;
            win_hit   <= 1'b0;
            spawned_q <= 1'b0;
            won_q     <= 1'b0;
            over_q    <= 1'b0;
            board_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        moved_q   <= bus.moved;
                        empty_cnt <= '0;
                        idx       <= '0;
                        any_pair  <= 1'b0;
                        win_hit   <= 1'b0;
                        state     <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (is_empty)         empty_cnt <= empty_cnt + 1'b1;
                    if (pair_hit)         any_pair  <= 1'b1;
                    if (cur >= WIN_CELL)  win_hit   <= 1'b1;
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX)  state <= S_PICK;
                end
                S_PICK: begin
                    seen  <= '0;
                    state <= no_spawn ? S_FINISH : S_PLACE;
                end
                S_PLACE: begin
                    if (is_empty)         seen <= seen + 1'b1;
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX)  state <= S_FINISH;
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase

            // Results are registered on entry to FINISH so they are valid with done.
            if (go_finish) begin
                board_q   <= work_w;
                spawned_q <= (state == S_PLACE);
                won_q     <= won_q | win_hit;
                over_q    <= over_q | ((empty_cnt == '0) && !any_pair);
            end
        end
    end

    // Working board, spawn target and spawn value carry no reset.
    always_ff @(posedge clk) begin
        if ((state == S_IDLE) && bus.start) work <= bus.board_in;
        else if (state == S_PLACE)          work <= work_w;
        if (state == S_PICK) begin
            target    <= prod[PROD_W-1:IDX_W];
            spawn_val <= spawn_nx;
        end
    end

    assign bus.board_out = board_q;
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_FINISH);
    assign bus.spawned   = spawned_q;
    assign bus.game_won  = won_q;
    assign bus.game_over = over_q;
endmodule

// File: tb/tb_tile_spawner.sv
// tb_tile_spawner: directed checks of tile_spawner covering reset/abort,
// single-empty spawn, no-move, full board game-over, win, and a spawn
// distribution run with ignored start pulses while busy.
module tb_tile_spawner;
    import game_pkg::*;

`ifdef SPAWN_FOUR_EN
    localparam bit FOUR_EN = 1'b1;
`else
    localparam bit FOUR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tile_spawner_if bus ();

    tile_spawner dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference LFSR: x^16+x^14+x^13+x^11+1, left shift, seed ACE1.
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= 16'hACE1;
        else      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    int          passed = 0;
    int          total  = 0;
    int          lat;
    logic [15:0] snap;
    board_t      res, zb, eb;

    function automatic int diff_count(board_t a, board_t b);
        int n = 0;
        for (int r = 0; r < BOARD_N; r++)
            for (int c = 0; c < BOARD_N; c++)
                if (a[r][c] !== b[r][c]) n++;
        return n;
    endfunction

    function automatic int exp_index(board_t b, logic [15:0] s);
        int cnt = 0;
        int tgt;
        int k = 0;
        for (int i = 0; i < CELLS; i++) if (b[i / BOARD_N][i % BOARD_N] == '0) cnt++;
        tgt = (int'(s[5:0]) * cnt) >> 6;
        for (int i = 0; i < CELLS; i++) begin
            if (b[i / BOARD_N][i % BOARD_N] == '0) begin
                if (k == tgt) return i;
                k++;
            end
        end
        return -1;
    endfunction

    function automatic int exp_val(logic [15:0] s);
        return (FOUR_EN && (s[9:7] == 3'b000)) ? 4 : 2;
    endfunction

    function automatic int cell_at(board_t b, int i);
        if (i < 0) return -1;
        return int'(b[i / BOARD_N][i % BOARD_N]);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Issues one start, waits (bounded) for done, records latency and the LFSR at PICK.
    task automatic run_op(input board_t b, input logic mv, input bit noise);
        @(negedge clk);
        bus.board_in = b;
        bus.moved    = mv;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.moved    = 1'b0;
        lat  = -1;
        snap = 16'h0;
        for (int c = 1; c <= 200; c++) begin
            if (c > 1) @(negedge clk);
            if (noise) begin
                bus.start    = (c == 10) || (c == 100);
                bus.moved    = 1'b1;
                bus.board_in = eb;
            end
            if (c == 65) snap = m_lfsr;
            if (bus.done === 1'b1) begin
                lat = c;
                break;
            end
        end
        bus.start = 1'b0;
        res = bus.board_out;
    endtask

    task automatic test_reset();
        int ei;
        bit done_seen;
        total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL rst_done: got %b want 0", bus.done); else passed++;
        total++; if ({bus.spawned, bus.game_won, bus.game_over} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {bus.spawned, bus.game_won, bus.game_over}); else passed++;
        total++; if (bus.board_out !== zb) $display("FAIL rst_board: got %0d changed cells want 0", diff_count(bus.board_out, zb)); else passed++;
        run_op(zb, 1'b1, 1'b0);
        // Abort a second operation in the middle of PLACE.
        @(negedge clk);
        bus.board_in = zb; bus.moved = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (100) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", bus.busy); else passed++;
        total++; if (bus.board_out !== zb) $display("FAIL abort_board: got %0d nonzero cells want 0", diff_count(bus.board_out, zb)); else passed++;
        total++; if ({bus.spawned, bus.game_won, bus.game_over} !== 3'b000) $display("FAIL abort_flags: got %b want 000", {bus.spawned, bus.game_won, bus.game_over}); else passed++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        done_seen = 1'b0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen = 1'b1;
        end
        total++; if (done_seen !== 1'b0) $display("FAIL abort_no_done: got %b want 0", done_seen); else passed++;
        run_op(zb, 1'b1, 1'b0);
        ei = exp_index(zb, snap);
        total++; if (cell_at(res, ei) !== exp_val(snap)) $display("FAIL lfsr_restart: got cell %0d = %0d want %0d", ei, cell_at(res, ei), exp_val(snap)); else passed++;
    endtask

    task automatic test_single_empty();
        board_t b;
        do_reset();
        for (int r = 0; r < BOARD_N; r++) for (int c = 0; c < BOARD_N; c++) b[r][c] = cell_t'(8);
        b[3][5] = '0;
        run_op(b, 1'b1, 1'b0);
        total++; if (lat !== 130) $display("FAIL single_latency: got %0d want 130", lat); else passed++;
        total++; if (bus.spawned !== 1'b1) $display("FAIL single_spawned: got %b want 1", bus.spawned); else passed++;
        total++; if (int'(res[3][5]) !== exp_val(snap)) $display("FAIL single_value: got %0d want %0d", res[3][5], exp_val(snap)); else passed++;
        total++; if (diff_count(res, b) !== 1) $display("FAIL single_changed: got %0d want 1", diff_count(res, b)); else passed++;
        total++; if (bus.game_over !== 1'b0) $display("FAIL single_over: got %b want 0", bus.game_over); else passed++;
    endtask

    task automatic test_no_move();
        board_t prev;
        prev = res;
        repeat (5) @(negedge clk);
        total++; if (bus.board_out !== prev) $display("FAIL hold_board: got %0d changed cells want 0", diff_count(bus.board_out, prev)); else passed++;
        run_op(zb, 1'b0, 1'b0);
        total++; if (lat !== 66) $display("FAIL nomove_latency: got %0d want 66", lat); else passed++;
        total++; if (bus.spawned !== 1'b0) $display("FAIL nomove_spawned: got %b want 0", bus.spawned); else passed++;
        total++; if (res !== zb) $display("FAIL nomove_board: got %0d changed cells want 0", diff_count(res, zb)); else passed++;
    endtask

    task automatic test_full_no_pairs();
        board_t b;
        do_reset();
        for (int r = 0; r < BOARD_N; r++)
            for (int c = 0; c < BOARD_N; c++)
                b[r][c] = ((r + c) % 2 == 0) ? cell_t'(2) : cell_t'(4);
        run_op(b, 1'b1, 1'b0);
        total++; if (lat !== 66) $display("FAIL full_latency: got %0d want 66", lat); else passed++;
        total++; if (bus.spawned !== 1'b0) $display("FAIL full_spawned: got %b want 0", bus.spawned); else passed++;
        total++; if (bus.game_over !== 1'b1) $display("FAIL full_over: got %b want 1", bus.game_over); else passed++;
        total++; if (res !== b) $display("FAIL full_board: got %0d changed cells want 0", diff_count(res, b)); else passed++;
        run_op(zb, 1'b1, 1'b0);
        total++; if (bus.game_over !== 1'b1) $display("FAIL over_sticky: got %b want 1", bus.game_over); else passed++;
    endtask

    task automatic test_win();
        board_t b;
        int ei;
        do_reset();
        for (int i = 0; i < CELLS; i++)
            b[i / BOARD_N][i % BOARD_N] = (i >= 1 && i <= 10) ? cell_t'(0) : cell_t'(2);
        b[0][0] = cell_t'(256);
        total++; if (bus.game_won !== 1'b0) $display("FAIL win_before: got %b want 0", bus.game_won); else passed++;
        run_op(b, 1'b1, 1'b0);
        ei = exp_index(b, snap);
        total++; if (lat !== 130) $display("FAIL win_latency: got %0d want 130", lat); else passed++;
        total++; if (bus.game_won !== 1'b1) $display("FAIL win_flag: got %b want 1", bus.game_won); else passed++;
        total++; if (diff_count(res, b) !== 1) $display("FAIL win_changed: got %0d want 1", diff_count(res, b)); else passed++;
        total++; if (cell_at(res, ei) !== exp_val(snap)) $display("FAIL win_cell: got cell %0d = %0d want %0d", ei, cell_at(res, ei), exp_val(snap)); else passed++;
        run_op(zb, 1'b0, 1'b0);
        total++; if (bus.game_won !== 1'b1) $display("FAIL win_sticky: got %b want 1", bus.game_won); else passed++;
    endtask

    task automatic test_distribution();
        int fours = 0;
        int ei;
        int ev;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            run_op(zb, 1'b1, (n % 2) == 1);
            ei = exp_index(zb, snap);
            ev = exp_val(snap);
            if (cell_at(res, ei) == 4) fours++;
            total++;
            if (lat !== 130 || diff_count(res, zb) !== 1 || cell_at(res, ei) !== ev)
                $display("FAIL dist_op%0d: got lat %0d changed %0d cell %0d = %0d want lat 130 changed 1 value %0d",
                         n, lat, diff_count(res, zb), ei, cell_at(res, ei), ev);
            else passed++;
        end
        if (FOUR_EN) begin
            total++; if (fours < 32 || fours > 68) $display("FAIL dist_fours: got %0d want 32..68", fours); else passed++;
        end else begin
            total++; if (fours !== 0) $display("FAIL dist_fours: got %0d want 0", fours); else passed++;
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.moved    = 1'b0;
        bus.board_in = '0;
        zb = '0;
        for (int r = 0; r < BOARD_N; r++) for (int c = 0; c < BOARD_N; c++) eb[r][c] = cell_t'(8);
        repeat (3) @(negedge clk);
        #1;
        test_reset();
        test_single_empty();
        test_no_move();
        test_full_no_pairs();
        test_win();
        test_distribution();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
